// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants for the GF(2^233) multiplier arbiter.
// Field width, FSM state encoding and watchdog defaults.
package ecc_pkg;

    localparam int ECC_W           = 233;
    localparam int ECC_TIMEOUT_CYC = 250;
    localparam int ECC_CW          = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/ecc_mul_arbiter_if.sv
// ecc_mul_arbiter_if: requester and multiplier signals of the arbiter.
// The master modport is the arbiter itself, slave is its environment.
interface ecc_mul_arbiter_if
    import ecc_pkg::*;
#(
    parameter int W = ECC_W
) ();

    logic         REQ0;
    logic [W-1:0] A0;
    logic [W-1:0] B0;
    logic         GNT0;
    logic         RES0_VALID;

    logic         REQ1;
    logic [W-1:0] A1;
    logic [W-1:0] B1;
    logic         GNT1;
    logic         RES1_VALID;

    logic [W-1:0] RES;
    logic         ERR;
    logic         BUSY;

    logic [W-1:0] MUL_DIN1;
    logic [W-1:0] MUL_DIN2;
    logic         MUL_IN_VALID;
    logic [W-1:0] MUL_DOUT;
    logic         MUL_OUT_VALID;

    modport master (
        input  REQ0, A0, B0,
        output GNT0, RES0_VALID,
        input  REQ1, A1, B1,
        output GNT1, RES1_VALID,
        output RES, ERR, BUSY,
        output MUL_DIN1, MUL_DIN2, MUL_IN_VALID,
        input  MUL_DOUT, MUL_OUT_VALID
    );

    modport slave (
        output REQ0, A0, B0,
        input  GNT0, RES0_VALID,
        output REQ1, A1, B1,
        input  GNT1, RES1_VALID,
        input  RES, ERR, BUSY,
        input  MUL_DIN1, MUL_DIN2, MUL_IN_VALID,
        output MUL_DOUT, MUL_OUT_VALID
    );

endinterface

// File: rtl/ecc_rr_arb2.sv
// ecc_rr_arb2: two-way round-robin grant selection.
// Pure combinational; the pointer register lives with the caller.
module ecc_rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_rr_ptr,
    output logic o_gnt_vld,
    output logic o_gnt_idx,
    output logic o_both
);

    // Pick the lone requester, or the pointer's choice on contention
    always_comb begin
        o_gnt_vld = i_req0 | i_req1;
        o_both    = i_req0 & i_req1;
        o_gnt_idx = 1'b0;
        unique case (1'b1)
            (i_req0 & i_req1):  o_gnt_idx = i_rr_ptr;
            (i_req1 & ~i_req0): o_gnt_idx = 1'b1;
            default:            o_gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ecc_mul_arbiter.sv
// ecc_mul_arbiter: shares one GF(2^233) multiplier between two requesters.
// Round-robin grant, registered operands, watchdog abort, spurious-strobe filter.
module ecc_mul_arbiter
    import ecc_pkg::*;
#(
    parameter int W           = ECC_W,
    parameter int TIMEOUT_CYC = ECC_TIMEOUT_CYC,
    parameter int CW          = ECC_CW
) (
    input  logic              CLK,
    input  logic              RST_N,
    ecc_mul_arbiter_if.master bus
);

    localparam logic [CW-1:0] LP_WDOG_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]    r_state;
    logic          r_rr_ptr;
    logic          r_owner;
    logic          r_err;
    logic          r_gnt0;
    logic          r_gnt1;
    logic [CW-1:0] r_wdog;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_din1;
    logic [W-1:0]  r_din2;

    logic          w_gnt_vld;
    logic          w_gnt_idx;
    logic          w_both;
    logic          w_grant;
    logic          w_done;
    logic          w_abort;
    logic          w_resp;
    logic [W-1:0]  w_a_sel;
    logic [W-1:0]  w_b_sel;

    ecc_rr_arb2 u_arb (
        .i_req0    (bus.REQ0),
        .i_req1    (bus.REQ1),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx),
        .o_both    (w_both)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_vld;
    assign w_done  = (r_state == ST_BUSY) && bus.MUL_OUT_VALID;
    assign w_abort = (r_state == ST_BUSY) && !bus.MUL_OUT_VALID
                     && (r_wdog == LP_WDOG_LAST);
    assign w_resp  = (r_state == ST_RESP);
    assign w_a_sel = w_gnt_idx ? bus.A1 : bus.A0;
    assign w_b_sel = w_gnt_idx ? bus.B1 : bus.B0;

    // Control FSM: grant, issue, wait for done or timeout, respond
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_err    <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
        end else begin
            r_gnt0 <= w_grant && !w_gnt_idx;
            r_gnt1 <= w_grant && w_gnt_idx;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner <= w_gnt_idx;
                        if (w_both) begin
                            r_rr_ptr <= ~w_gnt_idx;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state <= ST_RESP;
                    end else if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Watchdog: cleared on issue, counts every cycle spent waiting
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wdog <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wdog <= '0;
        end else if (r_state == ST_BUSY) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Operand capture on grant; operands then hold until the next grant
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_din1 <= '0;
            r_din2 <= '0;
        end else if (w_grant) begin
            r_din1 <= w_a_sel;
            r_din2 <= w_b_sel;
        end
    end

    // Result register: product on done, zero on timeout, else held
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_res <= '0;
        end else if (w_done) begin
            r_res <= bus.MUL_DOUT;
        end else if (w_abort) begin
            r_res <= '0;
        end
    end

    assign bus.GNT0         = r_gnt0;
    assign bus.GNT1         = r_gnt1;
    assign bus.RES0_VALID   = w_resp && !r_owner;
    assign bus.RES1_VALID   = w_resp && r_owner;
    assign bus.ERR          = w_resp && r_err;
    assign bus.BUSY         = (r_state != ST_IDLE);
    assign bus.RES          = r_res;
    assign bus.MUL_DIN1     = r_din1;
    assign bus.MUL_DIN2     = r_din2;
    assign bus.MUL_IN_VALID = (r_state == ST_ISSUE);

endmodule

// File: tb/tb_ecc_mul_arbiter.sv
// tb_ecc_mul_arbiter: self-checking bench for ecc_mul_arbiter.
// Stub multiplier (xor / GF product / hang), vector table, random scoreboard.
module tb_ecc_mul_arbiter;
    import ecc_pkg::*;

    localparam int W  = 233;
    localparam int TO = 250;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ecc_mul_arbiter_if bus ();

    ecc_mul_arbiter #(
        .W           (W),
        .TIMEOUT_CYC (TO),
        .CW          (8)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        bit           owner;
        logic [W-1:0] v;
    } exp_t;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     lat_cfg;
    bit     hang;
    bit     real_mul;
    logic   spur;
    logic [W-1:0] spur_val;
    int     cnt;
    logic [W-1:0] d1, d2;
    bit     rnd_en;
    int     n_rnd;
    exp_t   q[$];
    bit     g_miv, g_din_ok, g_stray, g_mov_prev;

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [W-1:0] x;
        logic [W-1:0] red;
        r   = '0;
        x   = a;
        red = (233'd1 << 74) | 233'd1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ x;
            if (x[W-1]) x = {x[W-2:0], 1'b0} ^ red;
            else        x = {x[W-2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd233();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stub multiplier: answers lat_cfg cycles after start unless hung
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= 0;
            bus.MUL_OUT_VALID <= 1'b0;
            bus.MUL_DOUT      <= '0;
        end else begin
            bus.MUL_OUT_VALID <= 1'b0;
            if (bus.MUL_IN_VALID) begin
                cnt <= lat_cfg;
                d1  <= bus.MUL_DIN1;
                d2  <= bus.MUL_DIN2;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1 && !hang) begin
                    bus.MUL_OUT_VALID <= 1'b1;
                    bus.MUL_DOUT <= real_mul ? gf_mul(d1, d2) : (d1 ^ d2);
                end
            end
            if (spur) begin
                bus.MUL_OUT_VALID <= 1'b1;
                bus.MUL_DOUT      <= spur_val;
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout want event", nm);
    endtask

    task automatic monitor();
        bit p0, p1, pmov, ptr, g;
        exp_t e;
        p0 = 0; p1 = 0; pmov = 0; ptr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ptr = 0; p0 = 0; p1 = 0; pmov = 0;
                q.delete();
                continue;
            end
            if (bus.GNT0 || bus.GNT1) begin
                chki("gnt_overlap", int'(bus.GNT0 & bus.GNT1), 0);
                g = bus.GNT1;
                if (p0 && p1) begin
                    chki("rr_order", int'(g), int'(ptr));
                    ptr = !g;
                end else begin
                    chki("gnt_to_requester", int'(g ? p1 : p0), 1);
                end
                if (rnd_en) begin
                    e.owner = g;
                    e.v = g ? (bus.A1 ^ bus.B1) : (bus.A0 ^ bus.B0);
                    q.push_back(e);
                end
            end
            if (rnd_en && (bus.RES0_VALID || bus.RES1_VALID)) begin
                if (q.size() == 0) begin
                    bound_fail("rnd_unexpected_res");
                end else begin
                    e = q.pop_front();
                    n_rnd++;
                    chki("rnd_owner", int'(bus.RES1_VALID), int'(e.owner));
                    chk("rnd_res", bus.RES, e.v);
                    chki("rnd_err", int'(bus.ERR), 0);
                    chki("rnd_mov_prev", int'(pmov), 1);
                end
            end
            p0   = bus.REQ0;
            p1   = bus.REQ1;
            pmov = bus.MUL_OUT_VALID;
        end
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) bus.REQ0 = v;
        else          bus.REQ1 = v;
    endtask

    task automatic do_op(input int who, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int bound,
                         output logic [W-1:0] res, output logic err,
                         output int lat_g, output int lat_r);
        int t0, tg;
        bit seen, pmov;
        g_stray = 0; g_miv = 0; g_din_ok = 0; g_mov_prev = 0;
        res = '0; err = 0; lat_g = -1; lat_r = -1;
        @(posedge clk); #1;
        if (who == 0) begin bus.A0 = a; bus.B0 = b; end
        else          begin bus.A1 = a; bus.B1 = b; end
        set_req(who, 1'b1);
        t0 = cyc;
        seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (who == 0 ? bus.GNT0 : bus.GNT1) seen = 1;
        end
        if (!seen) begin
            bound_fail("op_gnt_wait");
            set_req(who, 1'b0);
            return;
        end
        tg       = cyc;
        lat_g    = tg - t0;
        g_miv    = bus.MUL_IN_VALID;
        g_din_ok = (bus.MUL_DIN1 == a) && (bus.MUL_DIN2 == b);
        @(posedge clk); #1;
        set_req(who, 1'b0);
        seen = 0;
        pmov = 0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            if (who == 0 ? bus.RES0_VALID : bus.RES1_VALID) begin
                seen = 1;
                res = bus.RES;
                err = bus.ERR;
                g_mov_prev = pmov;
            end else if (bus.RES0_VALID || bus.RES1_VALID || bus.ERR) begin
                g_stray = 1;
            end
            pmov = bus.MUL_OUT_VALID;
        end
        if (!seen) bound_fail("op_res_wait");
        else       lat_r = cyc - tg;
    endtask

    task automatic requester(input int who, input int n);
        bit seen;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            if (who == 0) begin bus.A0 = rnd233(); bus.B0 = rnd233(); end
            else          begin bus.A1 = rnd233(); bus.B1 = rnd233(); end
            set_req(who, 1'b1);
            seen = 0;
            for (int k = 0; k < 1500 && !seen; k++) begin
                @(negedge clk);
                if (who == 0 ? bus.GNT0 : bus.GNT1) seen = 1;
            end
            if (!seen) bound_fail("rnd_gnt_wait");
            @(posedge clk); #1;
            set_req(who, 1'b0);
        end
    endtask

    vec_t         tv[4];
    logic [W-1:0] res, ea, eb, exp_v, res_before;
    logic         err;
    int           lg, lr, t_resp;
    bit           seen, g, flag;

    initial begin
        tv[0] = '{who: 0, a: 233'h1, b: 233'h5, exp: 233'h4};
        tv[1] = '{who: 1, a: '1, b: '0, exp: '1};
        tv[2] = '{who: 0, a: 233'h1_2345_6789_abcd,
                  b: 233'h1_0000_0000_0000, exp: 233'h2345_6789_abcd};
        tv[3] = '{who: 1, a: 233'd1 << 232, b: 233'h1,
                  exp: (233'd1 << 232) | 233'd1};

        rst_n = 0; lat_cfg = 235; hang = 0; real_mul = 0;
        spur = 0; spur_val = '0; rnd_en = 0; n_rnd = 0; t_resp = 0;
        bus.REQ0 = 0; bus.REQ1 = 0;
        bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chki("rst_ctrl", int'({bus.GNT0, bus.GNT1, bus.RES0_VALID,
             bus.RES1_VALID, bus.ERR, bus.BUSY, bus.MUL_IN_VALID}), 0);
        chk("rst_res", bus.RES, '0);
        chk("rst_din1", bus.MUL_DIN1, '0);
        chk("rst_din2", bus.MUL_DIN2, '0);

        // contention from reset release: order 0,1,0,1
        bus.A0 = 233'h11; bus.B0 = 233'h22;
        bus.A1 = 233'h33; bus.B1 = 233'h50;
        bus.REQ0 = 1; bus.REQ1 = 1;
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int j = 0; j < 700 && !seen; j++) begin
                @(negedge clk);
                if (bus.GNT0 || bus.GNT1) seen = 1;
            end
            if (!seen) begin
                bound_fail("cont_gnt_wait");
                break;
            end
            g = bus.GNT1;
            chki($sformatf("cont_order%0d", k), int'(g), k % 2);
            if (k > 0) chki("cont_idle_gap", cyc - t_resp, 2);
            exp_v = g ? (bus.A1 ^ bus.B1) : (bus.A0 ^ bus.B0);
            @(posedge clk); #1;
            if (!g) begin
                if (k == 2) bus.REQ0 = 0;
                else begin bus.A0 = rnd233(); bus.B0 = rnd233(); end
            end else begin
                if (k == 3) bus.REQ1 = 0;
                else begin bus.A1 = rnd233(); bus.B1 = rnd233(); end
            end
            seen = 0;
            for (int j = 0; j < 400 && !seen; j++) begin
                @(negedge clk);
                if (g ? bus.RES1_VALID : bus.RES0_VALID) seen = 1;
            end
            if (!seen) begin
                bound_fail("cont_res_wait");
                break;
            end
            chk("cont_res", bus.RES, exp_v);
            chki("cont_err", int'(bus.ERR), 0);
            t_resp = cyc;
            @(negedge clk);
            chki("cont_idle_busy", int'(bus.BUSY), 0);
        end
        bus.REQ0 = 0; bus.REQ1 = 0;

        // vector table with the xor stub
        for (int i = 0; i < 4; i++) begin
            do_op(tv[i].who, tv[i].a, tv[i].b, 400, res, err, lg, lr);
            chki($sformatf("tv%0d_gnt_lat", i), lg, 1);
            chki($sformatf("tv%0d_miv", i), int'(g_miv), 1);
            chki($sformatf("tv%0d_din", i), int'(g_din_ok), 1);
            chk($sformatf("tv%0d_res", i), res, tv[i].exp);
            chki($sformatf("tv%0d_err", i), int'(err), 0);
            chki($sformatf("tv%0d_res_lat", i), lr, 237);
            chki($sformatf("tv%0d_mov_prev", i), int'(g_mov_prev), 1);
            chki($sformatf("tv%0d_stray", i), int'(g_stray), 0);
            chki($sformatf("tv%0d_din_hold", i),
                 int'(bus.MUL_DIN1 == tv[i].a && bus.MUL_DIN2 == tv[i].b), 1);
        end

        // timeout, then a normal op from requester 1
        hang = 1;
        do_op(0, 233'h7, 233'h9, 400, res, err, lg, lr);
        chki("to_err", int'(err), 1);
        chk("to_res", res, '0);
        chki("to_lat", lr, TO + 1);
        hang = 0;
        do_op(1, 233'hf0, 233'h0f, 400, res, err, lg, lr);
        chk("after_to_res", res, 233'hff);
        chki("after_to_err", int'(err), 0);

        // strobe on the last watchdog cycle wins; one cycle later loses
        lat_cfg = TO - 1;
        do_op(0, 233'h3, 233'h6, 400, res, err, lg, lr);
        chk("tie_res", res, 233'h5);
        chki("tie_err", int'(err), 0);
        chki("tie_lat", lr, TO + 1);
        lat_cfg = TO;
        do_op(1, 233'h3, 233'h6, 400, res, err, lg, lr);
        chk("late_res", res, '0);
        chki("late_err", int'(err), 1);
        lat_cfg = 235;

        // spurious strobe while idle
        res_before = bus.RES;
        @(posedge clk); #1;
        spur = 1; spur_val = 233'habcdef;
        @(posedge clk); #1;
        spur = 0;
        flag = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.RES0_VALID || bus.RES1_VALID || bus.ERR || bus.BUSY)
                flag = 1;
        end
        chki("idle_spur_ignored", int'(flag), 0);
        chk("idle_spur_res", bus.RES, res_before);

        // strobe ten cycles into a hung op ends it
        hang = 1;
        fork
            do_op(0, 233'h1, 233'h1, 400, res, err, lg, lr);
            begin
                seen = 0;
                for (int j = 0; j < 20 && !seen; j++) begin
                    @(negedge clk);
                    if (bus.GNT0) seen = 1;
                end
                repeat (10) @(posedge clk);
                #1;
                spur = 1; spur_val = 233'h5eed;
                @(posedge clk); #1;
                spur = 0;
            end
        join
        hang = 0;
        chk("busy_spur_res", res, 233'h5eed);
        chki("busy_spur_err", int'(err), 0);

        // randomized traffic against the scoreboard
        rnd_en = 1;
        fork
            requester(0, 5);
            requester(1, 5);
        join
        seen = 0;
        for (int j = 0; j < 600 && !seen; j++) begin
            @(negedge clk);
            if (!bus.BUSY) seen = 1;
        end
        if (!seen) bound_fail("rnd_drain");
        @(negedge clk);
        rnd_en = 0;
        chki("rnd_count", n_rnd, 10);
        chki("rnd_queue_empty", q.size(), 0);

        // asynchronous reset in the middle of an op
        @(posedge clk); #1;
        bus.A0 = 233'h1234; bus.B0 = 233'h4321; bus.REQ0 = 1;
        seen = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            if (bus.GNT0) seen = 1;
        end
        if (!seen) bound_fail("arst_gnt_wait");
        @(posedge clk); #1;
        bus.REQ0 = 0;
        repeat (50) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chki("arst_ctrl", int'({bus.GNT0, bus.GNT1, bus.RES0_VALID,
             bus.RES1_VALID, bus.ERR, bus.BUSY, bus.MUL_IN_VALID}), 0);
        chk("arst_res", bus.RES, '0);
        chk("arst_din1", bus.MUL_DIN1, '0);
        chk("arst_din2", bus.MUL_DIN2, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        flag = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.RES0_VALID || bus.RES1_VALID || bus.ERR || bus.BUSY)
                flag = 1;
        end
        chki("arst_no_old_result", int'(flag), 0);
        do_op(1, 233'h8, 233'h1, 400, res, err, lg, lr);
        chki("arst_fresh_gnt_lat", lg, 1);
        chk("arst_fresh_res", res, 233'h9);

        // GF(2^233) product path
        real_mul = 1;
        do_op(0, 233'h1, 233'h2, 400, res, err, lg, lr);
        chk("gf_1x2", res, 233'h2);
        do_op(1, 233'd1 << 232, 233'h2, 400, res, err, lg, lr);
        chk("gf_reduce", res, (233'd1 << 74) | 233'd1);
        ea = rnd233();
        eb = rnd233();
        do_op(0, ea, eb, 400, res, err, lg, lr);
        chk("gf_rand", res, gf_mul(ea, eb));
        chki("gf_rand_err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout want completion");
        $fatal(1, "global timeout");
    end

endmodule
